frame_buffer: RTL and testbench
===============================

Name: frame_buffer

Overview:
- Double-buffered 1-bit 320x200 framebuffer between the game logic (writer) and the VGA scan-out (reader).
- The display always reads the front bank. The game writes pixels into the back bank through a valid/ready handshake.
- Banks swap at the display's frame boundary once the writer signals its frame is complete.
- After each swap, the new back bank is cleared automatically before writes are accepted again.

Parameters:
FB_W, 320, pixels per line
FB_H, 200, lines per frame
ADDR_W, 16, bank address width (FB_W*FB_H = 64000 entries)

Ports:
clk  in  1  system clock (pixel-doubled VGA clock domain)
rst_n  in  1  asynchronous active-low reset
rd_en  in  1  read strobe from display
rd_x  in  9  read column (display h >> 1)
rd_y  in  8  read row (display v >> 1)
rd_pixel  out  1  registered front-bank pixel
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle when high with wr_valid
wr_x  in  9  write column
wr_y  in  8  write row
wr_pixel  in  1  write data
frame_done  in  1  one-cycle pulse: back bank fully drawn
next_frame  in  1  one-cycle pulse from display at end of active area
front_sel  out  1  index of the bank currently displayed
clearing  out  1  high while the clear sequencer runs

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, named clk / rst_n.
- Reset values: front_sel=0, rd_pixel=0, wr_ready=0, clearing=1. State=CLEAR_ALL, clear counter=0, done_latched=0.
- Addressing: addr = y*320 + x, computed as (y<<8)+(y<<6)+x in ADDR_W bits.
- Range check: a coordinate is in range iff x<FB_W and y<FB_H.
- Read port:
  - On rd_en, rd_pixel <= front bank [addr] with 1-cycle latency.
  - An out-of-range read gives 0.
  - While state=CLEAR_ALL, rd_pixel <= 0.
  - rd_en low: rd_pixel holds its value.
- Write port:
  - wr_ready = (state==DRAW) && !done_latched.
  - Transfer occurs when wr_valid && wr_ready; it writes wr_pixel into the back bank (!front_sel).
  - An out-of-range transfer completes the handshake but is dropped.
- State machine:
  - CLEAR_ALL:
    - Writes 0 to address cnt in both banks; cnt increments each cycle.
    - At cnt==FB_W*FB_H-1: cnt<=0, go to DRAW, clearing<=0.
  - DRAW:
    - Writes accepted.
    - frame_done sets done_latched, so wr_ready drops the next cycle. A write handshaking in the same cycle as frame_done still lands in the current back bank.
    - next_frame while done_latched, or coincident with frame_done: front_sel toggles, done_latched<=0, go to CLEAR.
    - next_frame without done: ignored. The old frame stays displayed.
  - CLEAR:
    - Writes 0 to the new back bank at cnt, one address per cycle.
    - Takes 64000 cycles, well under one frame (~718k clk).
    - On the last address: go to DRAW, clearing<=0.
    - frame_done and next_frame are ignored here.
- Reads never target the bank being written or cleared, so there are no read/write collisions outside CLEAR_ALL.
- Reset mid-operation: the asynchronous reset returns everything to the reset values. CLEAR_ALL restarts from address 0. RAM contents are not reset directly; the clear sequencer handles them.

Decomposition:
- Shared package:
  - FB_W, FB_H, FB_PIXELS constants.
  - State encoding: CLEAR_ALL=0, DRAW=1, CLEAR=2.
  - Address-compute function (y*320+x via shifts).
- One sub-module, fb_bank:
  - 1-bit simple dual-port RAM, 64000 deep, BRAM-inferable.
  - Synchronous write port.
  - Registered read with enable.
  - Instantiated twice; the top muxes write/clear traffic to the back bank.

Test Plan:
- Reset release -> clearing=1 and wr_ready=0 for exactly 64000 cycles. Then clearing=0, wr_ready=1. Reads of (0,0), (319,199) and (160,100) return 0.
- Write (5,7)=1, pulse frame_done, then next_frame -> front_sel 0->1; rd (5,7) returns 1 one cycle after rd_en. clearing=1 for 64000 cycles, then wr_ready=1.
- Write (320,0)=1 and (0,200)=1 -> both handshakes complete. After swap, rd (320,0)=0, rd (0,200)=0, and rd (0,0) is unchanged.
- next_frame with no frame_done -> front_sel unchanged, no clear. frame_done and next_frame in the same cycle -> swap occurs in that cycle.
- Assert rst_n=0 at clear count 30000 -> outputs go to reset values immediately. After release, the full 64000-cycle CLEAR_ALL reruns.
- wr_valid held high across frame_done -> a write in the frame_done cycle is stored. wr_ready=0 from the next cycle until the clear completes after swap.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared geometry, FSM encoding and addressing helpers for the double-buffered
// 1-bit framebuffer.
package frame_buffer_pkg;

    localparam int unsigned FB_W      = 320;
    localparam int unsigned FB_H      = 200;
    localparam int unsigned FB_PIXELS = FB_W * FB_H;
    localparam int unsigned ADDR_W    = 16;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        DRAW      = 2'd1,
        CLEAR     = 2'd2
    } fb_state_e;

    // y*320 + x without a multiplier; wraps in ADDR_W bits for off-screen input.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [8:0] x, input logic [7:0] y);
        logic [ADDR_W-1:0] yw;
        yw = {8'd0, y};
        return (yw << 8) + (yw << 6) + {7'd0, x};
    endfunction

    function automatic logic fb_in_range(input logic [8:0] x, input logic [7:0] y,
                                         input int unsigned lines);
        return (32'(x) < FB_W) && (32'(y) < lines);
    endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Display read port, game write handshake and frame-sync pulses of the framebuffer.
interface frame_buffer_if;

    logic       rd_en;
    logic [8:0] rd_x;
    logic [7:0] rd_y;
    logic       rd_pixel;
    logic       wr_valid;
    logic       wr_ready;
    logic [8:0] wr_x;
    logic [7:0] wr_y;
    logic       wr_pixel;
    logic       frame_done;
    logic       next_frame;
    logic       front_sel;
    logic       clearing;

    modport master (
        output rd_en, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_pixel, frame_done, next_frame,
        input  rd_pixel, wr_ready, front_sel, clearing
    );

    modport slave (
        input  rd_en, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_pixel, frame_done, next_frame,
        output rd_pixel, wr_ready, front_sel, clearing
    );

endinterface

// File: rtl/fb_bank.sv
// One 1-bit simple dual-port bank: synchronous write, registered read with enable.
// No reset so the array maps onto block RAM.
module fb_bank
    import frame_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = FB_PIXELS,
    parameter int unsigned AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic          wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic          rdata_o
);

    logic mem_q [DEPTH];
    logic rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 1-bit framebuffer: display reads the front bank, the game draws
// into the back bank, banks swap at the display frame boundary, then the new back bank is wiped.
module frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int unsigned LINES = FB_H
) (
    input  logic         clk,
    input  logic         rst_n,
    frame_buffer_if.slave bus
);

    localparam int unsigned       PIXELS    = FB_W * LINES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              front_q, front_d;
    logic              rd_vld_q, rd_sel_q;

    logic              wr_ready;
    logic              wr_xfer;
    logic              wr_in_range;
    logic              rd_ok;
    logic              sweeping;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] bank_waddr;
    logic              bank_wdata;
    logic              bank_we   [2];
    logic              bank_re   [2];
    logic              bank_dout [2];

    assign wr_ready    = (state_q == DRAW) && !done_q;
    assign wr_xfer     = bus.wr_valid && wr_ready;
    assign wr_in_range = fb_in_range(bus.wr_x, bus.wr_y, LINES);
    assign wr_addr     = fb_addr(bus.wr_x, bus.wr_y);
    assign rd_addr     = fb_addr(bus.rd_x, bus.rd_y);
    assign rd_ok       = fb_in_range(bus.rd_x, bus.rd_y, LINES) && (state_q != CLEAR_ALL);
    assign sweeping    = (state_q == CLEAR_ALL) || (state_q == CLEAR);
    assign bank_waddr  = sweeping ? cnt_q : wr_addr;
    assign bank_wdata  = !sweeping && bus.wr_pixel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        front_d = front_q;
        case (state_q)
            CLEAR_ALL, CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = DRAW;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            DRAW: begin
                // A frame_done coincident with next_frame swaps immediately.
                if (bus.next_frame && (done_q || bus.frame_done)) begin
                    front_d = !front_q;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end else if (bus.frame_done) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR_ALL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR_ALL;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            front_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            front_q <= front_d;
            if (bus.rd_en) begin
                rd_vld_q <= rd_ok;
                rd_sel_q <= front_q;
            end
        end
    end

    // CLEAR_ALL wipes both banks; otherwise only the back bank takes writes or clears.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_we[gi] = (state_q == CLEAR_ALL)
                               || (((state_q == CLEAR) || (wr_xfer && wr_in_range))
                                   && (front_q != 1'(gi)));
            assign bank_re[gi] = bus.rd_en && rd_ok && (front_q == 1'(gi));

            fb_bank #(
                .DEPTH (PIXELS),
                .AW    (ADDR_W)
            ) u_bank (
                .clk     (clk),
                .we_i    (bank_we[gi]),
                .waddr_i (bank_waddr),
                .wdata_i (bank_wdata),
                .re_i    (bank_re[gi]),
                .raddr_i (rd_addr),
                .rdata_o (bank_dout[gi])
            );
        end
    endgenerate

    assign bus.rd_pixel  = rd_vld_q && bank_dout[rd_sel_q];
    assign bus.wr_ready  = wr_ready;
    assign bus.front_sel = front_q;
    assign bus.clearing  = (state_q != DRAW);

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer, built with a reduced line count so every
// full-bank clear stays short while keeping the 320-pixel line addressing.
module tb_frame_buffer;

    localparam int LINES = 10;
    localparam int PIX   = 320 * LINES;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    frame_buffer_if fb_if ();

    frame_buffer #(.LINES(LINES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fb_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int q_x[$];
    int q_y[$];
    bit exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input int x, input int y, input bit e);
        q_x.push_back(x);
        q_y.push_back(y);
        exp_q.push_back(e);
    endtask

    // Issues every queued read back-to-back; each result is checked one cycle later.
    task automatic run_reads(input string tag);
        int   n;
        int   x;
        int   y;
        bit   e;
        logic got;
        n = q_x.size();
        for (int i = 0; i < n; i++) begin
            x = q_x.pop_front();
            y = q_y.pop_front();
            fb_if.rd_en = 1'b1;
            fb_if.rd_x  = 9'(x);
            fb_if.rd_y  = 8'(y);
            tick();
            e   = exp_q.pop_front();
            got = fb_if.rd_pixel;
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s rd(%0d,%0d): rd_pixel=%b expected %b", tag, x, y, got, e);
            end else begin
                $display("ok   %s rd(%0d,%0d): rd_pixel=%b", tag, x, y, got);
            end
        end
        fb_if.rd_en = 1'b0;
    endtask

    task automatic do_write(input int x, input int y, input bit p, input string tag);
        fb_if.wr_valid = 1'b1;
        fb_if.wr_x     = 9'(x);
        fb_if.wr_y     = 8'(y);
        fb_if.wr_pixel = p;
        n_cmp++;
        if (fb_if.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s wr(%0d,%0d) handshake: wr_ready=%b expected 1", tag, x, y, fb_if.wr_ready);
        end else begin
            $display("ok   %s wr(%0d,%0d)=%b accepted", tag, x, y, p);
        end
        tick();
        fb_if.wr_valid = 1'b0;
    endtask

    // Counts edges until clearing drops; must be exactly one bank sweep.
    task automatic wait_clear(input string tag);
        int n;
        bit saw_ready;
        n = 0;
        saw_ready = 1'b0;
        do begin
            tick();
            n++;
            if (fb_if.clearing === 1'b1 && fb_if.wr_ready !== 1'b0) saw_ready = 1'b1;
        end while (fb_if.clearing === 1'b1 && n < 2 * PIX);
        n_cmp++;
        if (n != PIX) begin
            n_bad++;
            $display("FAIL %s clear length: %0d cycles expected %0d", tag, n, PIX);
        end else begin
            $display("ok   %s clear length: %0d cycles", tag, n);
        end
        n_cmp++;
        if (saw_ready) begin
            n_bad++;
            $display("FAIL %s wr_ready during clear: seen 1 expected 0", tag);
        end
        n_cmp++;
        if (fb_if.wr_ready !== 1'b1 || fb_if.clearing !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after clear: wr_ready=%b clearing=%b expected 1/0",
                     tag, fb_if.wr_ready, fb_if.clearing);
        end
    endtask

    task automatic check_outs(input string tag, input bit fs, input bit px, input bit rdy, input bit clr);
        n_cmp++;
        if (fb_if.front_sel !== fs || fb_if.rd_pixel !== px ||
            fb_if.wr_ready !== rdy || fb_if.clearing !== clr) begin
            n_bad++;
            $display("FAIL %s: front_sel/rd_pixel/wr_ready/clearing=%b%b%b%b expected %b%b%b%b",
                     tag, fb_if.front_sel, fb_if.rd_pixel, fb_if.wr_ready, fb_if.clearing,
                     fs, px, rdy, clr);
        end else begin
            $display("ok   %s: outputs %b%b%b%b", tag, fs, px, rdy, clr);
        end
    endtask

    task automatic test_reset();
        fb_if.rd_en = 0; fb_if.rd_x = 0; fb_if.rd_y = 0;
        fb_if.wr_valid = 0; fb_if.wr_x = 0; fb_if.wr_y = 0; fb_if.wr_pixel = 0;
        fb_if.frame_done = 0; fb_if.next_frame = 0;
        #1 rst_n = 1'b0;
        #1;
        check_outs("reset values", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        wait_clear("power-up");
        push_read(0, 0, 1'b0);
        push_read(319, LINES - 1, 1'b0);
        push_read(160, LINES / 2, 1'b0);
        run_reads("power-up");
    endtask

    task automatic test_write_swap();
        do_write(5, 7, 1'b1, "swap");
        fb_if.frame_done = 1'b1;
        tick();
        fb_if.frame_done = 1'b0;
        check_outs("frame_done latched", 1'b0, 1'b0, 1'b0, 1'b0);
        fb_if.next_frame = 1'b1;
        tick();
        fb_if.next_frame = 1'b0;
        check_outs("after swap", 1'b1, 1'b0, 1'b0, 1'b1);
        wait_clear("swap");
        push_read(5, 7, 1'b1);
        push_read(6, 7, 1'b0);
        push_read(5, 7, 1'b1);
        run_reads("swap");
    endtask

    task automatic test_range_and_sync();
        fb_if.next_frame = 1'b1;
        tick();
        fb_if.next_frame = 1'b0;
        check_outs("lone next_frame", 1'b1, 1'b1, 1'b1, 1'b0);
        do_write(320, 0, 1'b1, "range");
        do_write(0, LINES, 1'b1, "range");
        do_write(0, 200, 1'b1, "range");
        do_write(1, 0, 1'b1, "range");
        fb_if.frame_done = 1'b1;
        fb_if.next_frame = 1'b1;
        tick();
        fb_if.frame_done = 1'b0;
        fb_if.next_frame = 1'b0;
        check_outs("coincident swap", 1'b0, 1'b1, 1'b0, 1'b1);
        wait_clear("range");
        push_read(1, 0, 1'b1);
        run_reads("range");
        tick();
        tick();
        check_outs("rd_pixel hold", 1'b0, 1'b1, 1'b1, 1'b0);
        push_read(320, 0, 1'b0);
        push_read(1, 0, 1'b1);
        push_read(0, 200, 1'b0);
        push_read(0, 0, 1'b0);
        push_read(0, 1, 1'b0);
        push_read(0, LINES - 1, 1'b0);
        run_reads("range");
    endtask

    task automatic test_done_write();
        fb_if.wr_valid   = 1'b1;
        fb_if.wr_x       = 9'd10;
        fb_if.wr_y       = 8'd3;
        fb_if.wr_pixel   = 1'b1;
        fb_if.frame_done = 1'b1;
        check_outs("write with frame_done", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        fb_if.frame_done = 1'b0;
        fb_if.wr_x       = 9'd11;
        check_outs("ready drop after done", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        fb_if.next_frame = 1'b1;
        tick();
        fb_if.next_frame = 1'b0;
        check_outs("swap with valid held", 1'b1, 1'b0, 1'b0, 1'b1);
        wait_clear("done-write");
        fb_if.wr_valid = 1'b0;
        push_read(10, 3, 1'b1);
        push_read(11, 3, 1'b0);
        push_read(10, 3, 1'b1);
        run_reads("done-write");
    endtask

    task automatic test_reset_mid();
        check_outs("before reset", 1'b1, 1'b1, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_outs("async reset in DRAW", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        repeat (PIX * 30000 / 64000) tick();
        check_outs("mid power-up clear", 1'b0, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async reset mid clear", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        wait_clear("restart");
        push_read(10, 3, 1'b0);
        push_read(5, 7, 1'b0);
        push_read(319, LINES - 1, 1'b0);
        run_reads("restart");
    endtask

    initial begin
        test_reset();
        test_write_swap();
        test_range_and_sync();
        test_done_write();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
